modport_fifo: RTL and testbench
===============================

MODPORT_FIFO -- requirements
Module: modport_fifo

Interface
REQ-001 Parameter DATA_W, default 8: data word width; only the default value is required to be verified.
REQ-002 Parameter DEPTH, default 16: storage entries; power of two; only the default value is required to be verified.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rstn, input, 1: reset; asynchronous and active-high (asserted = 1) despite the name.
REQ-005 Port push, input, 1: write request; data_in is written on the rising edge where push=1 and the write is accepted.
REQ-006 Port pop, input, 1: read request; the head entry is read on the rising edge where pop=1 and the read is accepted.
REQ-007 Port data_in, input, DATA_W: write data, sampled on the rising edge.
REQ-008 Port data_out, output, DATA_W: registered read data.
REQ-009 Port count, output, 5 (log2(DEPTH)+1): current occupancy, range 0..DEPTH.
REQ-010 Port fifo_empty, output, 1: high when count==0.
REQ-011 Port fifo_full, output, 1: high when count==DEPTH.

Function
REQ-012 The block SHALL be a first-in first-out buffer of DEPTH words, built from a circular array with write and read pointers of log2(DEPTH) bits.
REQ-013 A write is accepted when push=1 and (fifo_full=0 or pop=1); the accepted word is stored at the write pointer, and the write pointer increments modulo DEPTH.
REQ-014 A read is accepted when pop=1 and fifo_empty=0; on that edge data_out loads the head word, and the read pointer increments modulo DEPTH.
REQ-015 Read latency: the popped word is valid on data_out from the clock edge that accepts the pop and is stable until the next accepted pop.
REQ-016 data_out SHALL hold its last value when no read is accepted.
REQ-017 count SHALL change as follows: +1 for an accepted write only; -1 for an accepted read only; unchanged when both or neither are accepted.
REQ-018 fifo_empty and fifo_full SHALL be derived combinationally from the registered count, so they reflect the post-edge occupancy.
REQ-019 A push while full without pop SHALL be ignored: no write, and pointers, count and contents unchanged.
REQ-020 A pop while empty SHALL be ignored: no read, and data_out, pointers and count unchanged.
REQ-021 Simultaneous push and pop while empty: only the write is accepted; count becomes 1; data_out is unchanged.
REQ-022 Simultaneous push and pop while full: both are accepted; the oldest word goes to data_out, the new word is stored, and count stays DEPTH.
REQ-023 Simultaneous push and pop at 0<count<DEPTH: both are accepted and count is unchanged.
REQ-024 Pointer wrap-around from DEPTH-1 to 0 SHALL preserve FIFO order across any number of wraps.

Reset
REQ-025 While rstn=1, the following SHALL be cleared immediately, independent of clk: write pointer=0, read pointer=0, count=0, data_out=0.
REQ-026 During reset, fifo_empty=1 and fifo_full=0.
REQ-027 Storage array contents need not be cleared by reset.
REQ-028 Push and pop SHALL be ignored while rstn=1.
REQ-029 An assertion of rstn mid-operation SHALL discard all stored data.
REQ-030 The first edge after rstn falls SHALL operate normally.

Verification
REQ-031 Reset: assert rstn with push and pop idle -> count=0, fifo_empty=1, fifo_full=0, data_out=0x00.
REQ-032 Fill: push 16 words 0x00..0x0F -> count steps 1..16; fifo_full=1 after the 16th; a 17th push (0xAA) leaves count=16.
REQ-033 Drain: pop 16 times -> data_out sequence 0x00..0x0F; fifo_empty=1 afterwards; an extra pop leaves data_out=0x0F and count=0.
REQ-034 Simultaneous push+pop: at count=5, push and pop together -> count stays 5 and data_out is the oldest word.
REQ-035 Simultaneous push+pop at the limits: on empty -> count=1 and data_out unchanged; on full -> count=16 and data_out is the oldest word.
REQ-036 Wrap and mid-reset: run 40 random push/pop cycles, checking order against a model; assert rstn with count=7 -> count=0 at once, and after release a push of 0x3C then a pop returns 0x3C.

Source files
------------

// File: rtl/modport_fifo.sv
// Synchronous FIFO on a circular array with registered read data.
// The read is launched on the accepting edge, so the popped word is on data_out
// right after that edge and stays there until the next accepted pop.
// rstn is active-high despite its name and clears state asynchronously.
module modport_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        data_in,
  output logic [DATA_W-1:0]        data_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     fifo_empty,
  output logic                     fifo_full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              wr_en, rd_en;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(DEPTH));
  assign count      = count_q;
  assign data_out   = data_out_q;

  // When full, a concurrent pop frees the slot being written, so push is still accepted.
  assign wr_en = push && (!fifo_full || pop);
  assign rd_en = pop && !fifo_empty;

  // Next-state for pointers, occupancy and read data.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      data_out_d = mem_q[rd_ptr_q];
    end
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and output registers with asynchronous active-high clear.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage array; contents survive reset, but pointers make them unreachable.
  always_ff @(posedge clk) begin
    if (wr_en && !rstn) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_modport_fifo.sv
// Randomized self-checking bench for modport_fifo against a queue-based model.
module tb_modport_fifo;

  logic       clk;
  logic       rstn;
  logic       push;
  logic       pop;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [4:0] count;
  logic       fifo_empty;
  logic       fifo_full;

  int unsigned tests;
  int unsigned fails;

  logic [7:0] mq[$];
  logic [7:0] exp_dout;

  modport_fifo #(.DATA_W(8), .DEPTH(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .push       (push),
    .pop        (pop),
    .data_in    (data_in),
    .data_out   (data_out),
    .count      (count),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // One clock with the given request; the model applies the FIFO rules to the queue.
  task automatic cycle(input logic p, input logic q, input logic [7:0] d);
    bit full_b, wr, rd;
    push    = p;
    pop     = q;
    data_in = d;
    @(posedge clk);
    full_b = (mq.size() == 16);
    wr = p && (!full_b || q);
    rd = q && (mq.size() != 0);
    if (rd) exp_dout = mq.pop_front();
    if (wr) mq.push_back(d);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b1; push = 1'b0; pop = 1'b0; data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (count !== 5'd0) begin fails++; $display("FAIL reset_count actual=%0d required=0", count); end
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL reset_empty actual=%b required=1", fifo_empty); end
    tests++; if (fifo_full !== 1'b0) begin fails++; $display("FAIL reset_full actual=%b required=0", fifo_full); end
    tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL reset_dout actual=%h required=00", data_out); end
    push = 1'b1; pop = 1'b1; data_in = 8'h55;
    @(posedge clk); #1;
    tests++; if (count !== 5'd0) begin fails++; $display("FAIL reset_ignore_push actual=%0d required=0", count); end
    push = 1'b0; pop = 1'b0;
    #2 rstn = 1'b0;
    mq.delete();
    exp_dout = 8'h00;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 8'(i));
      tests++; if (count !== 5'(i + 1)) begin fails++; $display("FAIL fill_count[%0d] actual=%0d required=%0d", i, count, i + 1); end
      tests++; if (fifo_full !== (i == 15)) begin fails++; $display("FAIL fill_full[%0d] actual=%b required=%b", i, fifo_full, i == 15); end
    end
    cycle(1'b1, 1'b0, 8'hAA);
    tests++; if (count !== 5'd16) begin fails++; $display("FAIL fill_overflow_count actual=%0d required=16", count); end
    tests++; if (fifo_full !== 1'b1) begin fails++; $display("FAIL fill_overflow_full actual=%b required=1", fifo_full); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      tests++; if (data_out !== 8'(i)) begin fails++; $display("FAIL drain_dout[%0d] actual=%h required=%h", i, data_out, 8'(i)); end
      tests++; if (count !== 5'(15 - i)) begin fails++; $display("FAIL drain_count[%0d] actual=%0d required=%0d", i, count, 15 - i); end
    end
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL drain_empty actual=%b required=1", fifo_empty); end
    cycle(1'b0, 1'b1, 8'h00);
    tests++; if (data_out !== 8'h0F) begin fails++; $display("FAIL drain_underflow_dout actual=%h required=0f", data_out); end
    tests++; if (count !== 5'd0) begin fails++; $display("FAIL drain_underflow_count actual=%0d required=0", count); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'($urandom));
    cycle(1'b1, 1'b1, 8'($urandom));
    tests++; if (count !== 5'd5) begin fails++; $display("FAIL simul_count actual=%0d required=5", count); end
    tests++; if (data_out !== exp_dout) begin fails++; $display("FAIL simul_dout actual=%h required=%h", data_out, exp_dout); end
    while (mq.size() != 0) begin
      cycle(1'b0, 1'b1, 8'h00);
      tests++; if (data_out !== exp_dout) begin fails++; $display("FAIL simul_drain_dout actual=%h required=%h", data_out, exp_dout); end
    end
  endtask

  task automatic test_limits();
    logic [7:0] prev;
    prev = exp_dout;
    cycle(1'b1, 1'b1, 8'($urandom));
    tests++; if (count !== 5'd1) begin fails++; $display("FAIL limit_empty_count actual=%0d required=1", count); end
    tests++; if (data_out !== prev) begin fails++; $display("FAIL limit_empty_dout actual=%h required=%h", data_out, prev); end
    while (mq.size() < 16) cycle(1'b1, 1'b0, 8'($urandom));
    cycle(1'b1, 1'b1, 8'($urandom));
    tests++; if (count !== 5'd16) begin fails++; $display("FAIL limit_full_count actual=%0d required=16", count); end
    tests++; if (data_out !== exp_dout) begin fails++; $display("FAIL limit_full_dout actual=%h required=%h", data_out, exp_dout); end
    while (mq.size() != 0) begin
      cycle(1'b0, 1'b1, 8'h00);
      tests++; if (data_out !== exp_dout) begin fails++; $display("FAIL limit_drain_dout actual=%h required=%h", data_out, exp_dout); end
    end
  endtask

  task automatic test_random_wrap();
    for (int i = 0; i < 40; i++) begin
      cycle(1'($urandom), 1'($urandom), 8'($urandom));
      tests++;
      if (data_out !== exp_dout || count !== 5'(mq.size()) ||
          fifo_empty !== (mq.size() == 0) || fifo_full !== (mq.size() == 16)) begin
        fails++;
        $display("FAIL random[%0d] actual dout=%h count=%0d e=%b f=%b required dout=%h count=%0d",
                 i, data_out, count, fifo_empty, fifo_full, exp_dout, mq.size());
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 64 && mq.size() != 7; i++) begin
      if (mq.size() < 7) cycle(1'b1, 1'b0, 8'($urandom));
      else cycle(1'b0, 1'b1, 8'h00);
    end
    tests++; if (count !== 5'd7) begin fails++; $display("FAIL midreset_setup_count actual=%0d required=7", count); end
    #2 rstn = 1'b1;
    #1;
    tests++; if (count !== 5'd0) begin fails++; $display("FAIL midreset_count actual=%0d required=0", count); end
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL midreset_empty actual=%b required=1", fifo_empty); end
    tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL midreset_dout actual=%h required=00", data_out); end
    mq.delete();
    exp_dout = 8'h00;
    @(posedge clk);
    #3 rstn = 1'b0;
    cycle(1'b1, 1'b0, 8'h3C);
    tests++; if (count !== 5'd1) begin fails++; $display("FAIL postreset_push_count actual=%0d required=1", count); end
    cycle(1'b0, 1'b1, 8'h00);
    tests++; if (data_out !== 8'h3C) begin fails++; $display("FAIL postreset_pop_dout actual=%h required=3c", data_out); end
    tests++; if (count !== 5'd0) begin fails++; $display("FAIL postreset_pop_count actual=%0d required=0", count); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    exp_dout = 8'h00;
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_limits();
    test_random_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
